stroke_link_tx: RTL and testbench

//  Parametrised, buffered serial transmitter that carries cursor/stroke words
//  {x, y, color, stroke_width} from this FPGA to the peer over the single-ended

---
 rtl/stroke_link_tx.sv | 204 ++++++++++++++++++++
 tb/tb_stroke_link_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stroke_link_tx.sv
// Buffered serial transmitter for cursor/stroke words. Words are queued in a
// FIFO, consecutive duplicates are dropped, and each word is framed as
// preamble ones, a zero sync bit, MSB-first payload, optional even parity and
// trailing guard zeros. The line idles at 0.
module stroke_link_tx #(
  parameter int unsigned DATA_WIDTH    = 26,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned BIT_CYCLES    = 100,
  parameter int unsigned PREAMBLE_BITS = 4,
  parameter int unsigned GUARD_BITS    = 2,
  parameter bit          PARITY_EN     = 1'b1,
  parameter bit          DEDUP_EN      = 1'b1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          valid_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          ready_out,
  output logic                          data_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          drop_out
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned CycW = $clog2(BIT_CYCLES);
  localparam int unsigned IdxW = $clog2(DATA_WIDTH + PREAMBLE_BITS + GUARD_BITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSync,
    StData,
    StParity,
    StGuard
  } state_e;

  state_e                state_q, state_d;
  logic [CycW-1:0]       cyc_q, cyc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] last_q;
  logic                  last_vld_q;
  logic                  drop_q;

  logic dedup_hit;
  logic push;
  logic pop;
  logic fifo_empty;
  logic bit_end;

  // Ready comes from the registered count so a same-cycle pop never frees a slot.
  assign ready_out  = (count_q < CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign dedup_hit  = DEDUP_EN && last_vld_q && (data_in == last_q);
  assign push       = valid_in && ready_out && !dedup_hit;
  assign bit_end    = (cyc_q == CycW'(BIT_CYCLES - 1));

  assign busy_out       = (state_q != StIdle);
  assign fifo_count_out = count_q;
  assign drop_out       = drop_q;

  // Line level is a pure function of the current state and shift register.
  always_comb begin
    data_out = 1'b0;
    case (state_q)
      StPreamble: data_out = 1'b1;
      StData:     data_out = shreg_q[DATA_WIDTH-1];
      StParity:   data_out = par_q;
      default:    data_out = 1'b0;
    endcase
  end

  // Framing FSM: bit timing, per-state bit index and the FIFO pop/load.
  always_comb begin
    state_d = state_q;
    cyc_d   = '0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop     = 1'b0;

    if (state_q != StIdle) begin
      cyc_d = bit_end ? '0 : cyc_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        pop = !fifo_empty;
      end
      StPreamble: begin
        if (bit_end) begin
          if (idx_q == IdxW'(PREAMBLE_BITS - 1)) begin
            state_d = StSync;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StSync: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q << 1;
          if (idx_q == IdxW'(DATA_WIDTH - 1)) begin
            state_d = PARITY_EN ? StParity : StGuard;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StGuard;
          idx_d   = '0;
        end
      end
      StGuard: begin
        if (bit_end) begin
          if (idx_q == IdxW'(GUARD_BITS - 1)) begin
            state_d = StIdle;
            idx_d   = '0;
            // Chain straight into the next preamble without an idle cycle.
            pop     = !fifo_empty;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      state_d = StPreamble;
      idx_d   = '0;
      cyc_d   = '0;
      shreg_d = mem_q[rd_ptr_q];
      par_d   = ^mem_q[rd_ptr_q];
    end
  end

  // FIFO occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers and count guard them.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // State, pointers, dedup memory and drop pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      count_q  <= count_d;
      drop_q   <= valid_in && !ready_out;
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        last_q     <= data_in;
        last_vld_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stroke_link_tx.sv
// Bench for stroke_link_tx: two instances (parity+dedup, and neither), a
// line receiver per instance that decodes frames and checks them against a
// queue of expected words filled by the stimulus.
module tb_stroke_link_tx;

  localparam int BC = 4;
  localparam int DW = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, valid_a, ready_a, dout_a, busy_a, drop_a;
  logic [DW-1:0] data_a;
  logic [3:0]    cnt_a;
  logic          rst_b, valid_b, ready_b, dout_b, busy_b, drop_b;
  logic [DW-1:0] data_b;
  logic [3:0]    cnt_b;

  stroke_link_tx #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(8), .BIT_CYCLES(BC), .PREAMBLE_BITS(4),
    .GUARD_BITS(2), .PARITY_EN(1'b1), .DEDUP_EN(1'b1)
  ) u_dut_a (
    .clk_in(clk), .rst_in(rst_a), .valid_in(valid_a), .data_in(data_a),
    .ready_out(ready_a), .data_out(dout_a), .busy_out(busy_a),
    .fifo_count_out(cnt_a), .drop_out(drop_a)
  );

  stroke_link_tx #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(8), .BIT_CYCLES(BC), .PREAMBLE_BITS(4),
    .GUARD_BITS(2), .PARITY_EN(1'b0), .DEDUP_EN(1'b0)
  ) u_dut_b (
    .clk_in(clk), .rst_in(rst_b), .valid_in(valid_b), .data_in(data_b),
    .ready_out(ready_b), .data_out(dout_b), .busy_out(busy_b),
    .fifo_count_out(cnt_b), .drop_out(drop_b)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];

  // Running line statistics, owned by the negedge block below.
  int   drops_a = 0, busy_cyc_a = 0, rises_a = 0, busy_cyc_b = 0, rises_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  logic [3:0] peak_a = '0;
  logic peak_clr = 1'b0;
  int   base_drops, base_cyc_a, base_rises_a, base_cyc_b, base_rises_b;

  always @(negedge clk) begin
    if (drop_a) drops_a <= drops_a + 1;
    if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
    if (busy_a && !prev_a) rises_a <= rises_a + 1;
    if (busy_b) busy_cyc_b <= busy_cyc_b + 1;
    if (busy_b && !prev_b) rises_b <= rises_b + 1;
    prev_a <= busy_a;
    prev_b <= busy_b;
    if (peak_clr) peak_a <= '0;
    else if (cnt_a > peak_a) peak_a <= cnt_a;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic line_of(input int w);
    return (w == 0) ? dout_a : dout_b;
  endfunction

  function automatic logic rst_of(input int w);
    return (w == 0) ? rst_a : rst_b;
  endfunction

  // Expected frame, bit k = k-th bit on the line.
  function automatic logic [63:0] build(input logic [DW-1:0] wd, input bit par_en);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k] = 1'b1;
    for (int j = 0; j < DW; j++) v[5+j] = wd[DW-1-j];
    if (par_en) v[5+DW] = ^wd;
    return v;
  endfunction

  // Receiver: a frame starts at the first 1 on the line; every bit must hold
  // its value for all BC cycles. Frames cut by reset are discarded.
  task automatic rx_loop(input int w);
    int            nb;
    logic [63:0]   got;
    logic          stable;
    bit            abort;
    logic [DW-1:0] word;
    nb = (w == 0) ? 34 : 33;
    forever begin
      @(negedge clk);
      if (rst_of(w) || line_of(w) !== 1'b1) continue;
      got = '0;
      stable = 1'b1;
      abort = 1'b0;
      for (int i = 0; i < nb * BC; i++) begin
        if (i > 0) @(negedge clk);
        if (rst_of(w)) begin
          abort = 1'b1;
          break;
        end
        if (i % BC == 0) got[i/BC] = line_of(w);
        else if (line_of(w) !== got[i/BC]) stable = 1'b0;
      end
      if (abort) continue;
      if ((w == 0 && q_a.size() == 0) || (w == 1 && q_b.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame dut%0d: got %0h expected no frame", w, got);
      end else begin
        word = (w == 0) ? q_a.pop_front() : q_b.pop_front();
        check((w == 0) ? "frame_a" : "frame_b", got, build(word, w == 0));
        check("bit_hold", {63'd0, stable}, 64'd1);
      end
    end
  endtask

  initial rx_loop(0);
  initial rx_loop(1);

  task automatic push(input int w, input logic [DW-1:0] wd, input bit acc);
    if (w == 0) begin
      valid_a = 1'b1;
      data_a  = wd;
      if (acc) q_a.push_back(wd);
    end else begin
      valid_b = 1'b1;
      data_b  = wd;
      if (acc) q_b.push_back(wd);
    end
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic clear_stats();
    base_drops   = drops_a;
    base_cyc_a   = busy_cyc_a;
    base_rises_a = rises_a;
    base_cyc_b   = busy_cyc_b;
    base_rises_b = rises_b;
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
  endtask

  task automatic wait_idle(input int w, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (w == 0 && !busy_a && cnt_a == 0) begin done = 1'b1; break; end
      if (w == 1 && !busy_b && cnt_b == 0) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle dut%0d: still busy after %0d cycles", w, budget);
    end
    repeat (4) @(negedge clk);
    check("frames_all_seen", (w == 0) ? q_a.size() : q_b.size(), 0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("rst_dout", dout_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_ready", ready_a, 1);
    check("rst_drop", drop_a, 0);

    // 1: single frame, latency and length
    clear_stats();
    push(0, 26'h2AB_CDEF, 1'b1);
    @(negedge clk);
    check("t1_count_queued", cnt_a, 1);
    check("t1_dout_before", dout_a, 0);
    check("t1_busy_before", busy_a, 0);
    @(negedge clk);
    check("t1_first_one", dout_a, 1);
    check("t1_busy_rise", busy_a, 1);
    check("t1_count_popped", cnt_a, 0);
    wait_idle(0, 400);
    check("t1_frame_cycles", busy_cyc_a - base_cyc_a, 136);
    check("t1_frames", rises_a - base_rises_a, 1);

    // 2: duplicates dropped with dedup, all sent without
    clear_stats();
    push(0, 26'h0000001, 1'b1);
    push(0, 26'h0000001, 1'b0);
    push(0, 26'h0000001, 1'b0);
    wait_idle(0, 400);
    check("t2_peak_count", peak_a, 1);
    check("t2_no_drop", drops_a - base_drops, 0);
    check("t2_frames", rises_a - base_rises_a, 1);
    clear_stats();
    push(1, 26'h0000001, 1'b1);
    push(1, 26'h0000001, 1'b1);
    push(1, 26'h0000001, 1'b1);
    wait_idle(1, 800);
    check("t2b_busy_cycles", busy_cyc_b - base_cyc_b, 396);
    check("t2b_back_to_back", rises_b - base_rises_b, 1);

    // 3: overflow the FIFO
    clear_stats();
    for (int i = 0; i < 10; i++) push(0, 26'h0A0000 + DW'(i), i < 9);
    @(negedge clk);
    check("t3_drop_pulse", drop_a, 1);
    check("t3_count_full", cnt_a, 8);
    check("t3_ready_low", ready_a, 0);
    @(negedge clk);
    check("t3_drop_one_cycle", drop_a, 0);
    wait_idle(0, 2000);
    check("t3_drops", drops_a - base_drops, 1);
    check("t3_busy_cycles", busy_cyc_a - base_cyc_a, 1224);
    check("t3_back_to_back", rises_a - base_rises_a, 1);

    // 4: parity values and parity-less frame length
    push(0, 26'h3FF_FFFF, 1'b1);
    wait_idle(0, 400);
    push(0, 26'h000_0007, 1'b1);
    wait_idle(0, 400);
    clear_stats();
    push(1, 26'h3FF_FFFF, 1'b1);
    wait_idle(1, 400);
    check("t4b_frame_cycles", busy_cyc_b - base_cyc_b, 132);

    // 5: reset mid-DATA with words queued
    for (int i = 0; i < 4; i++) push(0, 26'h0B0000 + DW'(i), 1'b1);
    repeat (60) @(posedge clk);
    #1;
    rst_a = 1'b1;
    q_a.delete();
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(negedge clk);
    check("t5_dout", dout_a, 0);
    check("t5_busy", busy_a, 0);
    check("t5_count", cnt_a, 0);
    check("t5_ready", ready_a, 1);
    clear_stats();
    repeat (300) @(negedge clk);
    check("t5_no_frames", rises_a - base_rises_a, 0);
    push(0, 26'h0B0003, 1'b1);
    wait_idle(0, 400);
    check("t5_resent", rises_a - base_rises_a, 1);

    // 6: push while full on the last guard cycle
    clear_stats();
    for (int i = 0; i < 9; i++) push(0, 26'h0C0000 + DW'(i), 1'b1);
    repeat (128) @(posedge clk);
    #1;
    valid_a = 1'b1;
    data_a  = 26'h0C00FF;
    @(negedge clk);
    check("t6_count_full", cnt_a, 8);
    check("t6_guard_line", dout_a, 0);
    check("t6_guard_busy", busy_a, 1);
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    @(negedge clk);
    check("t6_drop", drop_a, 1);
    check("t6_count_after_pop", cnt_a, 7);
    check("t6_preamble", dout_a, 1);
    check("t6_busy", busy_a, 1);
    wait_idle(0, 2000);
    check("t6_back_to_back", rises_a - base_rises_a, 1);
    check("t6_busy_cycles", busy_cyc_a - base_cyc_a, 1224);
    check("t6_drops", drops_a - base_drops, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
